keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner: drives one-hot row strobes, samples column returns through a synchroniser, debounces a single pressed key and reports its linear code with a one-cycle valid pulse plus a held-key level. Generalises the fixed four-row sweep to any row/column count, adds scan pacing by an external tick, press/release debounce and key encoding. Sits between the keypad pins and the key-consumer logic in the `clk_div` domain.

## Interface
- `NUM_ROWS`, 4, number of driven rows (≥2)
- `NUM_COLS`, 4, number of sensed columns (≥1)
- `DEBOUNCE_SCANS`, 4, consecutive agreeing ticks required to accept a press or a release (≥1)
- `SYNC_STAGES`, 2, flip-flop stages on `col` (≥2)
- `clk_div`  in  1  sole clock
- `rst`  in  1  reset, asynchronous, active-high
- `scan_tick`  in  1  single-cycle strobe pacing the scan; period ≥ `SYNC_STAGES`+1 cycles
- `col`  in  `NUM_COLS`  raw column lines, active-high, asynchronous
- `row`  out  `NUM_ROWS`  one-hot row drive
- `key_code`  out  `$clog2(NUM_ROWS*NUM_COLS)`  last accepted key, `r*NUM_COLS + c`
- `key_valid`  out  1  one-cycle pulse on acceptance of a press
- `key_down`  out  1  level, high from acceptance until release is accepted

## Operation
- `col` passes through `SYNC_STAGES` flops → `col_s`. All decisions use `col_s` only on cycles with `scan_tick`=1; other cycles change no state.
- Row index `r` and `row = 1<<r`; `row` always exactly one-hot, never zero.
- States: SCAN, DEBOUNCE, HOLD, RELEASE.
- SCAN, on tick: `col_s` exactly one bit set (bit `c`) → latch candidate (`r`,`c`), count=1, → DEBOUNCE, row frozen. `col_s`=0 or ≥2 bits set → stay, `r` advances (`NUM_ROWS-1` wraps to 0).
- DEBOUNCE, on tick: `col_s` equals one-hot of candidate `c` → count+1; count reaching `DEBOUNCE_SCANS` → HOLD, `key_code` loaded, `key_valid` pulsed, `key_down`=1. Any mismatch → SCAN, `r` advances, nothing reported.
- `DEBOUNCE_SCANS`=1: acceptance goes directly SCAN→HOLD on the detecting tick.
- HOLD, on tick: candidate bit set → stay (other columns ignored). Bit clear → RELEASE, count=1 (`DEBOUNCE_SCANS`=1: straight to SCAN as below).
- RELEASE, on tick: bit clear → count+1; reaching `DEBOUNCE_SCANS` → SCAN, `key_down`=0, `r` advances. Bit set → HOLD, count cleared.
- `key_code` holds its value until the next acceptance.
- Counter width `$clog2(DEBOUNCE_SCANS+1)`; never exceeds `DEBOUNCE_SCANS`.
- Reset (any time, incl. mid-DEBOUNCE/HOLD): state SCAN, `r`=0, `row`=…0001, `key_code`=0, `key_valid`=0, `key_down`=0, count=0, sync flops 0. No pulse generated by reset.

## Timing
- All outputs registered; respond the cycle after the qualifying tick edge.
- Press latency: `key_valid` high one cycle after the `DEBOUNCE_SCANS`-th matching tick (detecting tick counts as first).
- `key_valid` exactly one cycle wide, coincident with first cycle of `key_down`=1 and new `key_code`.
- Release latency: `key_down` falls, and `row` advances, one cycle after the `DEBOUNCE_SCANS`-th clear tick.
- Column change visible in `col_s` after `SYNC_STAGES` cycles; sampling is valid because `row` is stable ≥ `SYNC_STAGES`+1 cycles before each tick.
- `scan_tick` during reset ignored; first tick after deassertion samples row 0.

## Structure
- Package `keypad_pkg`: state enum (SCAN, DEBOUNCE, HOLD, RELEASE), code-width helper function.
- Sub-module `row_sequencer`: one-hot ring of `NUM_ROWS` with `advance` input, exports index `r` and `row`; async reset to row 0.
- Synchroniser, FSM, counter and encoder in the top.

## Test plan
- Reset: assert `rst` mid-cycle → `row`=0001, `key_code`=0, `key_valid`=0, `key_down`=0 immediately; 6 ticks with `col`=0 → `row` 0010,0100,1000,0001,0010,0100.
- 4×4, debounce 4: hold col bit 1 whenever row 2 driven → `key_valid` one cycle after 4th matching tick, `key_code`=9, `key_down`=1, `row` frozen at 0100.
- Bounce: col bit 1 on row 2 for 2 ticks then 0 → no `key_valid`, return to SCAN, next `row`=1000.
- Multi-key: `col`=0011 on row 1 → ignored, `row` advances, no pulse; release from HOLD over 4 clear ticks → `key_down` falls, `row` wraps 1000→0001 when pressed on row 3.
- Release glitch: in RELEASE after 2 clear ticks bit returns → back to HOLD, `key_down` stays 1, no second `key_valid`; async `rst` in HOLD → all outputs reset values.
- 3×5, debounce 1: press row 2 col 4 → `key_code`=14, `key_valid` one cycle after the detecting tick.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad scanner.
// Holds the scan FSM state encoding and a width helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_RELEASE
  } state_e;

  // Index width that stays at least one bit for single-entry ranges
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/row_sequencer.sv
// row_sequencer: one-hot ring driving the keypad rows.
// Steps to the next row on advance_i, wrapping to row 0.
module row_sequencer
  import keypad_pkg::*;
#(
  parameter  int NUM_ROWS = 4,
  localparam int RW       = clog2_min1(NUM_ROWS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                advance_i,
  output logic [RW-1:0]       idx_o,
  output logic [NUM_ROWS-1:0] row_o
);

  logic [RW-1:0]       idx_q, idx_d;
  logic [NUM_ROWS-1:0] row_q, row_d;

  // Next row: rotate the one-hot and bump the index together
  always_comb begin
    idx_d = idx_q;
    row_d = row_q;
    if (advance_i) begin
      if (idx_q == RW'(NUM_ROWS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + RW'(1);
      end
      row_d = {row_q[NUM_ROWS-2:0], row_q[NUM_ROWS-1]};
    end
  end

  // Row register, reset to row 0 so the drive is never all-zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      row_q <= NUM_ROWS'(1);
    end else begin
      idx_q <= idx_d;
      row_q <= row_d;
    end
  end

  assign idx_o = idx_q;
  assign row_o = row_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scan, debounce and key encoding.
// One key at a time; code = row * NUM_COLS + col.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                                  clk_div,
  input  logic                                  rst,
  input  logic                                  scan_tick,
  input  logic [NUM_COLS-1:0]                   col,
  output logic [NUM_ROWS-1:0]                   row,
  output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]  key_code,
  output logic                                  key_valid,
  output logic                                  key_down
);

  localparam int RW  = clog2_min1(NUM_ROWS);
  localparam int CCW = clog2_min1(NUM_COLS);
  localparam int CW  = $clog2(NUM_ROWS * NUM_COLS);
  localparam int NW  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [NW-1:0] CNT_ONE  = NW'(1);
  localparam logic [NW-1:0] CNT_DONE = NW'(DEBOUNCE_SCANS);

  logic [NUM_COLS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_COLS-1:0] col_s;

  state_e        state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CCW-1:0] cand_q, cand_d;
  logic [CW-1:0] code_q, code_d;
  logic          valid_q, valid_d;
  logic          down_q, down_d;

  logic          adv;
  logic [RW-1:0] row_idx;

  logic [CCW-1:0]      hit_c;
  logic                col_one;
  logic [NUM_COLS-1:0] cand_mask;
  logic                cand_hit;
  logic [NW-1:0]       cnt_inc;
  logic [CW-1:0]       code_hit;
  logic [CW-1:0]       code_cand;

  // Column synchroniser chain for the asynchronous returns
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= col;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign col_s = sync_q[SYNC_STAGES-1];

  row_sequencer #(
    .NUM_ROWS (NUM_ROWS)
  ) u_rows (
    .clk_i     (clk_div),
    .rst_i     (rst),
    .advance_i (adv),
    .idx_o     (row_idx),
    .row_o     (row)
  );

  // Column encoder: index of the set bit, meaningful when one-hot
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col_s[i]) begin
        hit_c = CCW'(i);
      end
    end
  end

  assign col_one   = ($countones(col_s) == 1);
  assign cand_mask = NUM_COLS'(1) << cand_q;
  assign cand_hit  = |(col_s & cand_mask);
  assign cnt_inc   = cnt_q + CNT_ONE;
  assign code_hit  = CW'(int'(row_idx) * NUM_COLS + int'(hit_c));
  assign code_cand = CW'(int'(row_idx) * NUM_COLS + int'(cand_q));

  // Scan FSM: only tick cycles move state; valid drops after one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;
    adv     = 1'b0;
    if (scan_tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (col_one) begin
            cand_d = hit_c;
            if (CNT_ONE == CNT_DONE) begin
              state_d = ST_HOLD;
              cnt_d   = '0;
              code_d  = code_hit;
              valid_d = 1'b1;
              down_d  = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CNT_ONE;
            end
          end else begin
            adv = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (col_s == cand_mask) begin
            if (cnt_inc == CNT_DONE) begin
              state_d = ST_HOLD;
              cnt_d   = '0;
              code_d  = code_cand;
              valid_d = 1'b1;
              down_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_SCAN;
            cnt_d   = '0;
            adv     = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!cand_hit) begin
            if (CNT_ONE == CNT_DONE) begin
              state_d = ST_SCAN;
              cnt_d   = '0;
              down_d  = 1'b0;
              adv     = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_RELEASE: begin
          if (cand_hit) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
            down_d  = 1'b0;
            adv     = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM, counter and output registers
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q <= ST_SCAN;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      down_q  <= down_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: random and directed keypad stimulus
// against a key-level reference model for two configurations.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] col4, row4, code4;
  logic       v4, d4;
  logic [4:0] col3;
  logic [2:0] row3;
  logic [3:0] code3;
  logic       v3, d3;

  always #5 clk = ~clk;

  keypad_scanner #(
    .NUM_ROWS(4), .NUM_COLS(4),
    .DEBOUNCE_SCANS(4), .SYNC_STAGES(2)
  ) u4 (
    .clk_div(clk), .rst(rst), .scan_tick(tick),
    .col(col4), .row(row4), .key_code(code4),
    .key_valid(v4), .key_down(d4)
  );

  keypad_scanner #(
    .NUM_ROWS(3), .NUM_COLS(5),
    .DEBOUNCE_SCANS(1), .SYNC_STAGES(2)
  ) u3 (
    .clk_div(clk), .rst(rst), .scan_tick(tick),
    .col(col3), .row(row3), .key_code(code3),
    .key_valid(v3), .key_down(d3)
  );

  typedef struct {
    int ph;
    int r;
    int cnt;
    int cc;
    int code;
    int valid;
    int down;
  } mdl_t;

  mdl_t m4, m3;
  int keys4 [4];
  int keys3 [3];
  int total = 0;
  int bad = 0;
  int gap = 3;
  int ticks = 0;
  bit ticked = 0;
  bit rnd = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t m;
    m.ph = 0; m.r = 0; m.cnt = 0; m.cc = 0;
    m.code = 0; m.valid = 0; m.down = 0;
    return m;
  endfunction

  // ph: 0 idle scan, 1 candidate, 2 held, 3 releasing
  function automatic mdl_t step(mdl_t mi, int nr, int nc,
                                int ds, int cs);
    mdl_t m = mi;
    bit one = ($countones(cs) == 1);
    m.valid = 0;
    case (m.ph)
      0: begin
        if (one) begin
          m.cc = $clog2(cs); m.cnt = 1; m.ph = 1;
        end else m.r = (m.r + 1) % nr;
      end
      1: begin
        if (cs == (1 << m.cc)) m.cnt++;
        else begin
          m.ph = 0; m.cnt = 0; m.r = (m.r + 1) % nr;
        end
      end
      2: if (cs[m.cc] == 1'b0) begin m.ph = 3; m.cnt = 1; end
      default: begin
        if (cs[m.cc]) begin m.ph = 2; m.cnt = 0; end
        else m.cnt++;
      end
    endcase
    if (m.ph == 1 && m.cnt >= ds) begin
      m.ph = 2; m.cnt = 0; m.valid = 1; m.down = 1;
      m.code = m.r * nc + m.cc;
    end
    if (m.ph == 3 && m.cnt >= ds) begin
      m.ph = 0; m.cnt = 0; m.down = 0;
      m.r = (m.r + 1) % nr;
    end
    return m;
  endfunction

  task automatic rand_keys();
    int k;
    int r;
    foreach (keys4[i]) keys4[i] = 0;
    foreach (keys3[i]) keys3[i] = 0;
    k = $urandom_range(0, 3);
    if (k >= 1) begin
      r = $urandom_range(0, 3);
      keys4[r] = 1 << $urandom_range(0, 3);
      r = $urandom_range(0, 2);
      keys3[r] = 1 << $urandom_range(0, 4);
    end
    if (k == 2) begin
      r = $urandom_range(0, 3);
      keys4[r] |= 1 << $urandom_range(0, 3);
      r = $urandom_range(0, 2);
      keys3[r] |= 1 << $urandom_range(0, 4);
    end
    if (k == 3) begin
      r = $urandom_range(0, 3);
      keys4[r] = 1 << $urandom_range(0, 3);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("row4", row4, 1 << m4.r);
    chk("code4", code4, m4.code);
    chk("valid4", v4, m4.valid);
    chk("down4", d4, m4.down);
    chk("row3", row3, 1 << m3.r);
    chk("code3", code3, m3.code);
    chk("valid3", v3, m3.valid);
    chk("down3", d3, m3.down);
    if (ticked && rnd && $urandom_range(0, 5) == 0) rand_keys();
    ticked = 0;
    col4 = '0;
    for (int i = 0; i < 4; i++)
      if (row4 == 4'(1 << i)) col4 = 4'(keys4[i]);
    col3 = '0;
    for (int i = 0; i < 3; i++)
      if (row3 == 3'(1 << i)) col3 = 5'(keys3[i]);
    if (gap == 0) begin
      tick = 1'b1;
      gap = $urandom_range(2, 5);
    end else begin
      tick = 1'b0;
      gap--;
    end
    @(posedge clk);
    if (tick) begin
      m4 = step(m4, 4, 4, 4, keys4[m4.r]);
      m3 = step(m3, 3, 5, 1, keys3[m3.r]);
      ticked = 1;
      ticks++;
    end else begin
      m4.valid = 0;
      m3.valid = 0;
    end
  endtask

  task automatic wait_ticks(input int n);
    int t0 = ticks;
    for (int i = 0; i < n * 8 && ticks < t0 + n; i++) cyc();
    chk("tick_budget", ticks, t0 + n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    tick = 1'b1;
    #1;
    chk("rst_row4", row4, 4'b0001);
    chk("rst_code4", code4, 0);
    chk("rst_valid4", v4, 0);
    chk("rst_down4", d4, 0);
    chk("rst_row3", row3, 3'b001);
    chk("rst_down3", d3, 0);
    m4 = mreset();
    m3 = mreset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick = 1'b0;
    gap = 3;
    ticked = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    col4 = '0;
    col3 = '0;
    foreach (keys4[i]) keys4[i] = 0;
    foreach (keys3[i]) keys3[i] = 0;
    m4 = mreset();
    m3 = mreset();
    #1;
    chk("init_row4", row4, 4'b0001);
    chk("init_valid4", v4, 0);
    do_reset();

    wait_ticks(6);
    #1 chk("seq_row", row4, 4'b0100);

    keys4[2] = 2;
    wait_ticks(4);
    #1;
    chk("press_valid", v4, 1);
    chk("press_code", code4, 9);
    chk("press_down", d4, 1);
    chk("press_row", row4, 4'b0100);

    keys4[2] = 0;
    wait_ticks(4);
    #1;
    chk("rel_down", d4, 0);
    chk("rel_row", row4, 4'b1000);

    keys4[2] = 2;
    wait_ticks(5);
    keys4[2] = 0;
    wait_ticks(1);
    #1;
    chk("bounce_row", row4, 4'b1000);
    chk("bounce_down", d4, 0);

    keys4[1] = 3;
    wait_ticks(3);
    #1 chk("multi_row", row4, 4'b0100);
    keys4[1] = 0;

    keys4[3] = 1;
    wait_ticks(5);
    #1;
    chk("r3_code", code4, 12);
    chk("r3_down", d4, 1);
    keys4[3] = 0;
    wait_ticks(4);
    #1;
    chk("wrap_down", d4, 0);
    chk("wrap_row", row4, 4'b0001);

    keys4[0] = 4;
    wait_ticks(4);
    #1 chk("g_code", code4, 2);
    keys4[0] = 0;
    wait_ticks(2);
    keys4[0] = 4;
    wait_ticks(2);
    #1;
    chk("glitch_down", d4, 1);
    chk("glitch_row", row4, 4'b0001);
    do_reset();
    keys4[0] = 0;

    keys3[2] = 1 << 4;
    wait_ticks(3);
    #1;
    chk("k3_valid", v3, 1);
    chk("k3_code", code3, 14);
    chk("k3_down", d3, 1);
    keys3[2] = 0;
    wait_ticks(1);
    #1 chk("k3_rel", d3, 0);

    rnd = 1;
    wait_ticks(200);
    do_reset();
    wait_ticks(200);
    rnd = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
